// File: rtl/udma_cfg_apb_bridge.sv
// APB slave to uDMA peripheral configuration bus bridge.
// Each APB transfer becomes one one-hot cfg_valid/cfg_ready handshake, guarded by an optional timeout.
module udma_cfg_apb_bridge #(
  parameter int unsigned N_PERIPHS      = 8,
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT        = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [APB_ADDR_WIDTH-1:0]   apb_paddr_i,
  input  logic [31:0]                 apb_pwdata_i,
  input  logic                        apb_pwrite_i,
  input  logic                        apb_psel_i,
  input  logic                        apb_penable_i,
  output logic [31:0]                 apb_prdata_o,
  output logic                        apb_pready_o,
  output logic                        apb_pslverr_o,
  output logic [31:0]                 cfg_data_o,
  output logic [4:0]                  cfg_addr_o,
  output logic                        cfg_rwn_o,
  output logic [N_PERIPHS-1:0]        cfg_valid_o,
  input  logic [N_PERIPHS*32-1:0]     cfg_data_i,
  input  logic [N_PERIPHS-1:0]        cfg_ready_i
);

  localparam int unsigned ID_W    = APB_ADDR_WIDTH - 7;
  localparam int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4:0]            addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  rwn_q, rwn_d;
  logic [N_PERIPHS-1:0]  valid_q, valid_d;
  logic [31:0]           prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;

  logic [ID_W-1:0]       req_id_c;
  logic                  sel_ready_c;
  logic [31:0]           sel_rdata_c;
  logic                  unused_paddr;

  assign req_id_c     = apb_paddr_i[APB_ADDR_WIDTH-1:7];
  assign unused_paddr = ^apb_paddr_i[1:0];

  // Ready and read data of the peripheral currently being addressed.
  always_comb begin
    sel_ready_c = 1'b0;
    sel_rdata_c = '0;
    for (int unsigned k = 0; k < N_PERIPHS; k++) begin
      if (32'(id_q) == k) begin
        sel_ready_c = cfg_ready_i[k];
        sel_rdata_c = cfg_data_i[k*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rwn_d     = rwn_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    valid_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (apb_psel_i && apb_penable_i) begin
          addr_d = apb_paddr_i[6:2];
          data_d = apb_pwdata_i;
          rwn_d  = ~apb_pwrite_i;
          id_d   = req_id_c;
          cnt_d  = '0;
          if (32'(req_id_c) < N_PERIPHS) begin
            state_d = REQ;
          end else begin
            // Unmapped slot: answer with an error without touching the cfg bus.
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end
        end
      end
      REQ: begin
        if (sel_ready_c) begin
          prdata_d = rwn_q ? sel_rdata_c : 32'h0;
          cnt_d    = '0;
          state_d  = RESP;
          pready_d = 1'b1;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
          prdata_d  = '0;
          cnt_d     = '0;
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Valid is registered, so it follows the state being entered.
    for (int unsigned k = 0; k < N_PERIPHS; k++) begin
      valid_d[k] = (state_d == REQ) && (32'(id_d) == k);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rwn_q     <= 1'b1;
      valid_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rwn_q     <= rwn_d;
      valid_q   <= valid_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign apb_prdata_o  = prdata_q;
  assign apb_pready_o  = pready_q;
  assign apb_pslverr_o = pslverr_q;
  assign cfg_data_o    = data_q;
  assign cfg_addr_o    = addr_q;
  assign cfg_rwn_o     = rwn_q;
  assign cfg_valid_o   = valid_q;

endmodule

// File: tb/tb_udma_cfg_apb_bridge.sv
// Bench for udma_cfg_apb_bridge: transfer-level timing model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_udma_cfg_apb_bridge;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 12;
  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            rstn_i;
  logic [AW-1:0]   apb_paddr_i;
  logic [31:0]     apb_pwdata_i;
  logic            apb_pwrite_i;
  logic            apb_psel_i;
  logic            apb_penable_i;
  logic [31:0]     apb_prdata_o;
  logic            apb_pready_o;
  logic            apb_pslverr_o;
  logic [31:0]     cfg_data_o;
  logic [4:0]      cfg_addr_o;
  logic            cfg_rwn_o;
  logic [N-1:0]    cfg_valid_o;
  logic [N*32-1:0] cfg_data_i;
  logic [N-1:0]    cfg_ready_i;

  udma_cfg_apb_bridge #(.N_PERIPHS(N), .APB_ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .apb_paddr_i(apb_paddr_i), .apb_pwdata_i(apb_pwdata_i), .apb_pwrite_i(apb_pwrite_i),
    .apb_psel_i(apb_psel_i), .apb_penable_i(apb_penable_i),
    .apb_prdata_o(apb_prdata_o), .apb_pready_o(apb_pready_o), .apb_pslverr_o(apb_pslverr_o),
    .cfg_data_o(cfg_data_o), .cfg_addr_o(cfg_addr_o), .cfg_rwn_o(cfg_rwn_o),
    .cfg_valid_o(cfg_valid_o), .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i)
  );

  always #5 clk = ~clk;

  // Peripheral register files.
  logic [31:0] mem [N][32];

  // Expected outputs for the current cycle.
  logic [N-1:0] e_valid;
  logic         e_pready, e_chk_err, e_err, e_chk_rd, e_chk_cfg, e_rwn, e_first;
  logic [31:0]  e_rd, e_data;
  logic [4:0]   e_addr;
  int           e_j;

  // Per-transfer observations.
  int           st_vcnt = 0;
  logic [N-1:0] st_vor = '0;
  int           st_pr_j = -1;
  logic         st_err = 1'b0;
  logic [31:0]  st_rd = '0;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic set_idle_exp();
    e_valid = '0; e_pready = 1'b0; e_chk_err = 1'b0; e_err = 1'b0;
    e_chk_rd = 1'b0; e_rd = '0; e_chk_cfg = 1'b0; e_j = -1; e_first = 1'b0;
  endtask

  task automatic set_rst_exp();
    set_idle_exp();
    e_chk_err = 1'b1; e_chk_rd = 1'b1; e_chk_cfg = 1'b1;
    e_addr = '0; e_data = '0; e_rwn = 1'b1;
  endtask

  // Non-selected slots always report ready and junk data.
  task automatic drive_periph(input int id, input bit rdy, input int rg);
    for (int k = 0; k < int'(N); k++) begin
      cfg_ready_i[k] = (k == id) ? rdy : 1'b1;
      cfg_data_i[k*32 +: 32] = (k == id) ? mem[k][rg] : (32'hBAD0_0000 | 32'(k));
    end
  endtask

  always @(negedge clk) begin
    chk("valid", 32'(cfg_valid_o), 32'(e_valid));
    chk("pready", 32'(apb_pready_o), 32'(e_pready));
    if (e_chk_err) chk("pslverr", 32'(apb_pslverr_o), 32'(e_err));
    if (e_chk_rd) chk("prdata", apb_prdata_o, e_rd);
    if (e_chk_cfg) begin
      chk("cfg_addr", 32'(cfg_addr_o), 32'(e_addr));
      chk("cfg_data", cfg_data_o, e_data);
      chk("cfg_rwn", 32'(cfg_rwn_o), 32'(e_rwn));
    end
    if (e_first) begin
      st_vcnt <= 0; st_vor <= '0; st_pr_j <= -1; st_err <= 1'b0; st_rd <= '0;
    end else begin
      if (|cfg_valid_o) st_vcnt <= st_vcnt + 1;
      st_vor <= st_vor | cfg_valid_o;
      if (apb_pready_o) begin
        st_pr_j <= e_j; st_err <= apb_pslverr_o; st_rd <= apb_prdata_o;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      apb_psel_i = 1'b0; apb_penable_i = 1'b0;
      drive_periph(-1, 1'b1, 0);
      set_idle_exp();
    end
  endtask

  // One APB transfer; lat = REQ cycles the addressed peripheral keeps ready low.
  task automatic xfer(input logic [AW-1:0] addr, input logic [31:0] wd, input bit wr,
                      input int lat, input bit drop);
    int id, rg, r;
    bit ok, err;
    logic [31:0] rd;
    id = int'(addr[AW-1:7]);
    rg = int'(addr[6:2]);
    ok = (id < int'(N));
    if (!ok) begin
      r = 0; err = 1'b1; rd = '0;
    end else if (lat < int'(TO)) begin
      r = lat + 1; err = 1'b0; rd = wr ? 32'h0 : mem[id][rg];
    end else begin
      r = int'(TO); err = 1'b1; rd = '0;
    end
    @(posedge clk); #1;
    apb_psel_i = 1'b1; apb_penable_i = 1'b0;
    apb_paddr_i = addr; apb_pwdata_i = wd; apb_pwrite_i = wr;
    drive_periph(id, 1'b0, rg);
    set_idle_exp();
    e_first = 1'b1;
    for (int j = 0; j <= r + 1; j++) begin
      @(posedge clk); #1;
      apb_psel_i = !(drop && j >= 2);
      apb_penable_i = apb_psel_i;
      drive_periph(id, (j >= 1 + lat), rg);
      set_idle_exp();
      e_j = j;
      if (ok && j >= 1 && j <= r) begin
        e_valid = N'(1) << id; e_chk_cfg = 1'b1;
        e_addr = 5'(rg); e_data = wd; e_rwn = !wr;
      end
      if (j == r + 1) begin
        e_pready = 1'b1; e_chk_err = 1'b1; e_err = err; e_chk_rd = 1'b1; e_rd = rd;
      end
    end
    if (ok && wr && !err) mem[id][rg] = wd;
  endtask

  // Write to id 4 reg 1, interrupted by reset during REQ.
  task automatic xfer_reset();
    @(posedge clk); #1;
    apb_psel_i = 1'b1; apb_penable_i = 1'b0;
    apb_paddr_i = 12'h204; apb_pwdata_i = 32'hDEAD_BEEF; apb_pwrite_i = 1'b1;
    drive_periph(4, 1'b0, 1);
    set_idle_exp();
    @(posedge clk); #1;
    apb_penable_i = 1'b1;
    @(posedge clk); #1;
    e_valid = 8'h10; e_chk_cfg = 1'b1; e_addr = 5'd1; e_data = 32'hDEAD_BEEF; e_rwn = 1'b0;
    @(posedge clk); #1;
    #1 rstn_i = 1'b0;
    set_rst_exp();
    #1;
    chk("rst_async_valid", 32'(cfg_valid_o), 32'h0);
    chk("rst_async_rwn", 32'(cfg_rwn_o), 32'h1);
    @(posedge clk); #1;
    apb_psel_i = 1'b0; apb_penable_i = 1'b0;
    @(posedge clk); #1;
    rstn_i = 1'b1;
    set_idle_exp();
  endtask

  initial begin
    for (int k = 0; k < int'(N); k++)
      for (int r = 0; r < 32; r++)
        mem[k][r] = 32'h1000_0000 | 32'(k << 8) | 32'(r);
    mem[5][0] = 32'h0000_0ABC;
    mem[1][2] = 32'h5555_AAAA;
    rstn_i = 1'b0;
    apb_psel_i = 1'b0; apb_penable_i = 1'b0;
    apb_paddr_i = '0; apb_pwdata_i = '0; apb_pwrite_i = 1'b0;
    drive_periph(-1, 1'b1, 0);
    set_rst_exp();
    repeat (3) @(posedge clk);
    #1 rstn_i = 1'b1;
    set_idle_exp();
    idle(2);

    // Setup phase alone must be ignored.
    @(posedge clk); #1;
    apb_psel_i = 1'b1; apb_penable_i = 1'b0; apb_paddr_i = 12'h10C;
    idle(0);
    repeat (2) begin @(posedge clk); #1; end
    idle(1);

    xfer(12'h10C, 32'h0000_0031, 1'b1, 0, 1'b0);
    idle(1);
    chk("t1_vcnt", 32'(st_vcnt), 32'd1);
    chk("t1_vor", 32'(st_vor), 32'h04);
    chk("t1_pready_at", 32'(st_pr_j), 32'd2);
    chk("t1_err", 32'(st_err), 32'd0);

    xfer(12'h280, 32'h0, 1'b0, 0, 1'b0);
    idle(1);
    chk("t2_rd", st_rd, 32'h0000_0ABC);
    chk("t2_vor", 32'(st_vor), 32'h20);
    chk("t2_err", 32'(st_err), 32'd0);

    xfer(12'h480, 32'h0, 1'b0, 0, 1'b0);
    idle(1);
    chk("t3_vor", 32'(st_vor), 32'h0);
    chk("t3_pready_at", 32'(st_pr_j), 32'd1);
    chk("t3_err", 32'(st_err), 32'd1);
    chk("t3_rd", st_rd, 32'h0);

    xfer(12'h088, 32'h0, 1'b0, 100, 1'b0);
    idle(1);
    chk("t4_vcnt", 32'(st_vcnt), 32'd16);
    chk("t4_err", 32'(st_err), 32'd1);
    chk("t4_pready_at", 32'(st_pr_j), 32'd17);

    xfer(12'h088, 32'h0, 1'b0, 15, 1'b0);
    idle(1);
    chk("t4b_vcnt", 32'(st_vcnt), 32'd16);
    chk("t4b_err", 32'(st_err), 32'd0);
    chk("t4b_rd", st_rd, 32'h5555_AAAA);

    xfer(12'h190, 32'hCAFE_F00D, 1'b1, 1, 1'b0);
    xfer(12'h190, 32'h0, 1'b0, 0, 1'b0);
    idle(1);
    chk("t5_rd", st_rd, 32'hCAFE_F00D);
    chk("t5_vcnt", 32'(st_vcnt), 32'd1);

    xfer(12'h31C, 32'h1234_5678, 1'b1, 3, 1'b1);
    idle(1);
    chk("t6_vcnt", 32'(st_vcnt), 32'd4);
    chk("t6_pready_at", 32'(st_pr_j), 32'd5);

    xfer_reset();
    idle(2);
    xfer(12'h204, 32'h0, 1'b0, 0, 1'b0);
    idle(1);
    chk("t7_rd", st_rd, 32'h1000_0401);
    chk("t7_vor", 32'(st_vor), 32'h10);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
